// File: rtl/wb_burst_ram_if.sv
// Wishbone B3 bus bundle for wb_burst_ram; signal names follow the slave's view.
interface wb_burst_ram_if;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o;
  logic        err_o;

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, cyc_i, stb_i, cti_i, bte_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output adr_i, dat_i, we_i, sel_i, cyc_i, stb_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_burst_ram.sv
// Wishbone B3 block-RAM responder with registered feedback, classic cycles and
// CTI incrementing bursts (linear / wrap4 / wrap8 / wrap16) addressed internally.
module wb_burst_ram #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  wb_burst_ram_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam logic [2:0]  CTI_INCR = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_END} state_t;

  logic [31:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic          we_q,    we_d;
  logic [2:0]    cti_q,   cti_d;
  logic [1:0]    bte_q,   bte_d;
  logic          ack_q,   ack_d;
  logic          err_q,   err_d;
  logic [31:0]   dat_q,   dat_d;

  logic          wr_en_c;
  logic [31:0]   wr_word_c;
  logic [AW-1:0] nxt_addr_c;
  logic [AW-1:0] req_idx_c;
  logic          oor_c;
  logic          unused_adr_c;

  assign req_idx_c    = bus.adr_i[AW+1:2];
  assign oor_c        = |bus.adr_i[31:AW+2];
  assign unused_adr_c = &{1'b0, bus.adr_i[1:0]};

  // Next burst word: wrap modes only carry within the low 2/3/4 index bits.
  always_comb begin : p_next_addr
    logic [AW-1:0] inc_c;
    logic [AW-1:0] mask_c;
    inc_c = addr_q + AW'(1);
    case (bte_q)
      2'd1:    mask_c = AW'(3);
      2'd2:    mask_c = AW'(7);
      2'd3:    mask_c = AW'(15);
      default: mask_c = '1;
    endcase
    nxt_addr_c = (addr_q & ~mask_c) | (inc_c & mask_c);
  end

  // Current word after this edge's byte-masked write; feeds the read bypass.
  always_comb begin
    wr_word_c = mem_q[addr_q];
    for (int b = 0; b < 4; b++) begin
      if (bus.sel_i[b]) wr_word_c[8*b +: 8] = bus.dat_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cti_d   = cti_q;
    bte_d   = bte_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    wr_en_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cyc_i && bus.stb_i) begin
          addr_d = req_idx_c;
          we_d   = bus.we_i;
          cti_d  = bus.cti_i;
          bte_d  = bus.bte_i;
          if (oor_c) begin
            err_d   = 1'b1;
            state_d = S_END;
          end else if (LATENCY == 0) begin
            ack_d   = 1'b1;
            dat_d   = mem_q[req_idx_c];
            state_d = S_BURST;
          end else begin
            cnt_d   = CW'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!bus.cyc_i) begin
          state_d = S_END;
        end else if (cnt_q == '0) begin
          ack_d   = bus.stb_i;
          dat_d   = mem_q[addr_q];
          state_d = S_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_BURST: begin
        if (!bus.cyc_i) begin
          state_d = S_END;
        end else if (!bus.stb_i) begin
          ack_d = 1'b0;
        end else if (!ack_q) begin
          // Master resumed after a wait: no latency penalty.
          ack_d = 1'b1;
          dat_d = mem_q[addr_q];
        end else begin
          wr_en_c = we_q;
          if (cti_q != CTI_INCR || bus.cti_i != CTI_INCR) begin
            state_d = S_END;
          end else begin
            ack_d  = 1'b1;
            addr_d = nxt_addr_c;
            dat_d  = (wr_en_c && nxt_addr_c == addr_q) ? wr_word_c : mem_q[nxt_addr_c];
          end
        end
      end

      S_END: begin
        // An error cycle spends one extra cycle here so a quiet gap follows err_o.
        if (!err_q) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cti_q   <= '0;
      bte_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // RAM array is not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel_i[b]) mem_q[addr_q][8*b +: 8] <= bus.dat_i[8*b +: 8];
      end
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: table of classic cycles plus burst,
// wrap, stall, out-of-range and reset sequences checked through a scoreboard.
module tb_wb_burst_ram;

  localparam int unsigned AW      = 10;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_burst_ram_if bus ();

  wb_burst_ram #(.AW(AW), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] sb [$];

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [2:0]  cti;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] adr, input logic we,
                              input logic [3:0] sel, input logic [31:0] wd,
                              input logic [2:0] cti, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.adr = adr; v.we = we; v.sel = sel; v.wd = wd; v.cti = cti; v.exp = exp;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int unsigned next_word(input int unsigned a, input logic [1:0] bte);
    int unsigned size;
    case (bte)
      2'd1:    size = 4;
      2'd2:    size = 8;
      2'd3:    size = 16;
      default: size = DEPTH;
    endcase
    return (a - (a % size)) + ((a + 1) % size);
  endfunction

  task automatic idle_bus();
    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.sel_i = '0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.cti_i = '0; bus.bte_i = '0;
  endtask

  task automatic classic(input vec_t v);
    int  c;
    bit  got;
    logic [31:0] e;
    @(posedge clk); #1;
    bus.adr_i = v.adr; bus.we_i = v.we; bus.sel_i = v.sel; bus.dat_i = v.wd;
    bus.cti_i = v.cti; bus.bte_i = '0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    if (!v.we) sb.push_back(v.exp);
    got = 1'b0;
    c   = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      if (bus.ack_o) got = 1'b1;
      else c++;
    end
    check({v.name, " latency"}, 32'(c), 32'(1 + LATENCY));
    check({v.name, " err"}, 32'(bus.err_o), 32'd0);
    if (!v.we) begin
      e = sb.pop_front();
      if (got) check({v.name, " rdata"}, bus.dat_o, e);
    end else if (got) begin
      ref_mem[v.adr[AW+1:2]] = merge(ref_mem[v.adr[AW+1:2]], v.wd, v.sel);
    end
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check({v.name, " ack_drop"}, 32'(bus.ack_o), 32'd0);
  endtask

  task automatic burst(input string name, input logic [31:0] base, input int n, input logic we,
                       input logic [1:0] bte, input bit data_is_addr,
                       input int stall_after, input int stall_len);
    int unsigned a;
    int          beats;
    int          idle_cnt;
    logic [31:0] wd;
    a        = 32'(base[AW+1:2]);
    beats    = 0;
    idle_cnt = 0;
    wd       = data_is_addr ? a : $urandom;
    @(posedge clk); #1;
    bus.adr_i = base; bus.we_i = we; bus.sel_i = 4'hF; bus.bte_i = bte; bus.dat_i = wd;
    bus.cti_i = (n == 1) ? 3'b111 : 3'b010; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    if (!we) sb.push_back(ref_mem[a]);
    while (beats < n) begin
      @(negedge clk);
      if (!bus.ack_o) begin
        idle_cnt++;
        if (idle_cnt > 40) begin
          check({name, " timeout beats"}, 32'(beats), 32'(n));
          break;
        end
        continue;
      end
      idle_cnt = 0;
      if (!we) check($sformatf("%s beat%0d", name, beats), bus.dat_o, sb.pop_front());
      else ref_mem[a] = wd;
      beats++;
      a = next_word(a, bte);
      @(posedge clk); #1;
      if (beats == stall_after && beats < n) begin
        bus.stb_i = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          if (s > 0) check($sformatf("%s stall%0d ack", name, s), 32'(bus.ack_o), 32'd0);
          @(posedge clk); #1;
        end
      end
      if (beats < n) begin
        wd = data_is_addr ? a : $urandom;
        bus.dat_i = wd;
        bus.stb_i = 1'b1;
        bus.cti_i = (beats == n - 1) ? 3'b111 : 3'b010;
        if (!we) sb.push_back(ref_mem[a]);
      end else begin
        idle_bus();
      end
    end
    if (beats < n) begin
      idle_bus();
      sb.delete();
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({name, " ack_after"}, 32'(bus.ack_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [31:0] e;

    tbl.push_back(mk("w_beef",   32'h0000_0014, 1'b1, 4'hF, 32'hDEAD_BEEF, 3'b000, 32'h0));
    tbl.push_back(mk("w_aabb",   32'h0000_0020, 1'b1, 4'hF, 32'hAABB_CCDD, 3'b000, 32'h0));
    tbl.push_back(mk("w_sel5",   32'h0000_0020, 1'b1, 4'h5, 32'h1122_3344, 3'b000, 32'h0));
    tbl.push_back(mk("r_beef",   32'h0000_0014, 1'b0, 4'hF, 32'h0,         3'b000, 32'hDEAD_BEEF));
    tbl.push_back(mk("r_sel5",   32'h0000_0020, 1'b0, 4'hF, 32'h0,         3'b000, 32'hAA22_CC44));
    tbl.push_back(mk("w_selA",   32'h0000_0020, 1'b1, 4'hA, 32'h5566_7788, 3'b111, 32'h0));
    tbl.push_back(mk("r_selA",   32'h0000_0020, 1'b0, 4'hF, 32'h0,         3'b111, 32'h5522_7744));
    tbl.push_back(mk("w_top",    32'h0000_0FFC, 1'b1, 4'hF, 32'h0BAD_F00D, 3'b001, 32'h0));
    tbl.push_back(mk("r_top",    32'h0000_0FFC, 1'b0, 4'hF, 32'h0,         3'b000, 32'h0BAD_F00D));

    idle_bus();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", 32'(bus.ack_o), 32'd0);
    check("reset err", 32'(bus.err_o), 32'd0);
    check("reset dat", bus.dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) classic(tbl[i]);

    burst("init",   32'h0000_0000, 32, 1'b1, 2'd0, 1'b1, -1, 0);
    burst("incr8",  32'h0000_0040,  8, 1'b0, 2'd0, 1'b0, -1, 0);
    burst("wrap4",  32'h0000_0018,  4, 1'b0, 2'd1, 1'b0, -1, 0);
    burst("wrap8",  32'h0000_0034,  8, 1'b0, 2'd2, 1'b0, -1, 0);
    burst("lin_top",32'h0000_0FFC,  3, 1'b0, 2'd0, 1'b0, -1, 0);
    burst("stall_w",32'h0000_00A0,  8, 1'b1, 2'd0, 1'b0,  2, 3);
    burst("stall_r",32'h0000_00A0,  8, 1'b0, 2'd0, 1'b0, -1, 0);

    // Out-of-range write: one err cycle, no ack, word 0 untouched.
    @(posedge clk); #1;
    bus.adr_i = 32'h0001_0000; bus.we_i = 1'b1; bus.sel_i = 4'hF; bus.dat_i = 32'hFFFF_FFFF;
    bus.cti_i = 3'b000; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(negedge clk);
    check("oor c0 err", 32'(bus.err_o), 32'd0);
    @(negedge clk);
    check("oor c1 err", 32'(bus.err_o), 32'd1);
    check("oor c1 ack", 32'(bus.ack_o), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("oor c2 err", 32'(bus.err_o), 32'd0);
    check("oor c2 ack", 32'(bus.ack_o), 32'd0);
    classic(mk("oor_rd0", 32'h0000_0000, 1'b0, 4'hF, 32'h0, 3'b000, 32'h0000_0000));

    // Reset in the middle of an incrementing read burst.
    @(posedge clk); #1;
    bus.adr_i = 32'h0000_0040; bus.we_i = 1'b0; bus.sel_i = 4'hF; bus.cti_i = 3'b010;
    bus.bte_i = 2'd0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    sb.push_back(32'd16);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = bus.ack_o;
    end
    check("rst pre ack", 32'(got), 32'd1);
    e = sb.pop_front();
    check("rst pre data", bus.dat_o, e);
    #1 rst = 1'b0;
    #1;
    check("rst mid ack", 32'(bus.ack_o), 32'd0);
    check("rst mid dat", bus.dat_o, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b1;
    classic(mk("post_rst", 32'h0000_0014, 1'b0, 4'hF, 32'h0, 3'b000, 32'd5));

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_ram.md
Name: wb_burst_ram

Overview:
- Wishbone B3 slave (responder) backed by on-chip block RAM, with registered feedback.
- Serves classic single-beat cycles and CTI incrementing bursts with linear or wrapping BTE.
- Acts as the memory-side counterpart for the cache masters. It stands in for SDRAM in simulation and small FPGA builds.
- Burst masters hold adr_o at the burst base address for the whole burst and only count acks. This block therefore generates burst addresses internally.

Parameters:
- AW, 10, word-address bits; DEPTH = 2**AW 32-bit words.
- LATENCY, 2, idle cycles inserted before the first ack of any cycle (range 0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- adr_i  in  32  byte address; word index = adr_i[AW+1:2].
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- we_i  in  1  write enable.
- sel_i  in  4  byte enables; bit n enables byte [8n+7:8n].
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- cti_i  in  3  cycle type: 000 classic, 001 const, 010 incr, 111 end-of-burst.
- bte_i  in  2  burst type: 0 linear, 1 wrap4, 2 wrap8, 3 wrap16.
- ack_o  out  1  beat acknowledge.
- err_o  out  1  error acknowledge.

Behaviour:
- Reset (rst=0, asynchronous): ack_o=0, err_o=0, dat_o=0, state=S_IDLE, latency counter=0, address counter=0. RAM contents are unchanged.
- States:
  - S_IDLE, S_WAIT, S_BURST, S_END.
- S_IDLE:
  - Start condition: at an edge with cyc_i&stb_i=1. Latch word index into the address counter and latch we_i, cti_i, bte_i.
  - Out of range (adr_i[31:AW+2] != 0): err_o=1 for exactly one cycle, then go to S_END. No RAM access is made.
  - In range: go to S_WAIT with counter=LATENCY.
- S_WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, assert ack_o, go to S_BURST, and register dat_o=mem[addr].
  - LATENCY=0: ack_o is high in the cycle after the request is sampled.
- Latency: stb_i first high in cycle 0 → first ack_o in cycle 1+LATENCY.
- S_BURST, at each edge with ack_o=1:
  - Write: if we_i, write dat_i into mem[addr] under sel_i.
  - Last beat: if the latched cycle is classic or const, or cti_i==111, or cyc_i==0, drop ack_o and go to S_END.
  - Continue: else if cti_i==010 and stb_i=1, advance addr per BTE, register dat_o=mem[next addr] (pre-write contents are not reused: read-after-write to the same word returns the new data), and keep ack_o=1.
  - Master wait: else if stb_i==0 with cyc_i=1, drop ack_o and hold addr. When stb_i returns, re-assert ack_o at the next edge with no LATENCY penalty.
- S_END:
  - One cycle with ack_o=0 and err_o=0, then S_IDLE.
  - Guarantees the edge carrying the final ack never restarts a cycle.
  - Minimum gap between consecutive cycles: 1 idle cycle.
- Address advance, on AW-bit word index:
  - Linear: +1 modulo DEPTH (wraps silently, no error).
  - Wrap4/wrap8/wrap16: increment the low 2/3/4 bits modulo 4/8/16; upper bits stay fixed.
- Abort: cyc_i=0 at any point (S_WAIT or S_BURST) → no write for that edge, ack_o=0 next cycle, go to S_END.
- cti_i=111 on the first beat is a single-beat cycle.
- ack_o and err_o are never both high. Neither is ever high while cyc_i was 0 at the preceding edge.
- dat_o holds its last value when not acking. It is only meaningful when ack_o=1 and we_i=0.

Test Plan:
- LATENCY=2, AW=10, preload mem[5]=0xDEADBEEF; classic read adr_i=0x14 → ack_o high in cycle 3 only, dat_o=0xDEADBEEF, ack_o low cycle 4.
- Classic write adr_i=0x20, dat_i=0x11223344, sel_i=0101 over old value 0xAABBCCDD → mem[8]=0xAA22CC44; one ack.
- 8-beat incr linear read, adr_i held at 0x40, cti=010 on beats 1-7 and 111 on beat 8, mem[i]=i → dat_o=16..23 on consecutive ack cycles, exactly 8 acks, ack_o low after beat 8.
- Wrap4 read starting at word 6 → addresses 6,7,4,5. Linear burst starting at word 1023 → 1023,0,1.
- Master stalls stb_i low for 3 cycles after beat 2 of a write burst → no ack during the stall, beat 3 is written to base+2 on resume, total 8 writes.
- Out-of-range adr_i=0x00010000 → err_o for 1 cycle, no ack, RAM unchanged. Assert rst mid-burst → ack_o=0 immediately; the next request is served normally from S_IDLE.
